bin_window_buffer: RTL and testbench

- Parametrised successor to the single-threshold 3-tap binarising line buffer.
- Converts each 24-bit RGB camera pixel to 1-bit "white" using a programmable luma threshold.
- Stores NUM_TAPS+1 rotating 1-bit line buffers and presents a NUM_TAPS-high pixel column above the current x position, with a valid qualifier.
- Sits between the camera pixel stream and the ball-detection low-pass/blob logic. Fully synchronous to bit_clk; h_sync is sampled as data, never used as a clock.

---
 rtl/bin_window_buffer_pkg.sv | 31 +++
 rtl/bin_window_buffer_if.sv | 30 +++
 rtl/bin_window_buffer_line_ram.sv | 25 ++
 rtl/bin_window_buffer.sv | 167 ++++++++++++++++
 tb/tb_bin_window_buffer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_window_buffer_pkg.sv
// rtl/bin_window_buffer_pkg.sv - luma weights and bank-index helper for bin_window_buffer
package bin_window_pkg;

  localparam int LUMA_WR    = 9;
  localparam int LUMA_WG    = 19;
  localparam int LUMA_WB    = 4;
  localparam int LUMA_SHIFT = 5;
  localparam int THRESH_W   = 8;

  // Each weighted term is truncated before summing; the worst-case sum is 253, so 8 bits never overflow.
  function automatic logic [THRESH_W-1:0] luma(input logic [23:0] rgb);
    logic [12:0] r;
    logic [12:0] g;
    logic [12:0] b;
    logic [9:0]  sum;
    r   = 13'(rgb[23:16]) * 13'(LUMA_WR);
    g   = 13'(rgb[15:8])  * 13'(LUMA_WG);
    b   = 13'(rgb[7:0])   * 13'(LUMA_WB);
    sum = 10'(r >> LUMA_SHIFT) + 10'(g >> LUMA_SHIFT) + 10'(b >> LUMA_SHIFT);
    return sum[THRESH_W-1:0];
  endfunction

  // Bank holding tap k when bank sel is being written: (sel + 1 + k) mod nbuf.
  function automatic int bank_idx(input int sel, input int k, input int nbuf);
    int i;
    i = sel + 1 + k;
    if (i >= nbuf) i = i - nbuf;
    return i;
  endfunction

endpackage

// File: rtl/bin_window_buffer_if.sv
// rtl/bin_window_buffer_if.sv - pixel-in / tap-column-out bundle; vote signals exist only with BIN_WINDOW_VOTE_EN
interface bin_window_buffer_if #(
  parameter int NUM_TAPS = 3,
  parameter int X_W      = 10
);

  logic [23:0]         pixel;
  logic                h_sync;
  logic                v_sync;
  logic [X_W-1:0]      x_cont;
  logic [7:0]          thresh;
  logic [NUM_TAPS-1:0] taps;
  logic                tap_valid;
  logic [X_W-1:0]      tap_x;
`ifdef BIN_WINDOW_VOTE_EN
  logic                vote;
  logic                vote_valid;

  modport master (output pixel, h_sync, v_sync, x_cont, thresh,
                  input  taps, tap_valid, tap_x, vote, vote_valid);
  modport slave  (input  pixel, h_sync, v_sync, x_cont, thresh,
                  output taps, tap_valid, tap_x, vote, vote_valid);
`else
  modport master (output pixel, h_sync, v_sync, x_cont, thresh,
                  input  taps, tap_valid, tap_x);
  modport slave  (input  pixel, h_sync, v_sync, x_cont, thresh,
                  output taps, tap_valid, tap_x);
`endif

endinterface

// File: rtl/bin_window_buffer_line_ram.sv
// rtl/bin_window_buffer_line_ram.sv - 1-bit simple dual-port line RAM with registered read
module bin_line_ram #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          wren,
  input  logic [AW-1:0] wraddress,
  input  logic          data,
  input  logic [AW-1:0] rdaddress,
  output logic          q
);

  localparam int           IW      = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);

  logic mem [DEPTH];

  // Addresses past the line end are ignored on write and read back as 0.
  always_ff @(posedge clk) begin
    if (wren && ({1'b0, wraddress} < DEPTH_C)) mem[wraddress[IW-1:0]] <= data;
    q <= ({1'b0, rdaddress} < DEPTH_C) ? mem[rdaddress[IW-1:0]] : 1'b0;
  end

endmodule

// File: rtl/bin_window_buffer.sv
// rtl/bin_window_buffer.sv - binarising rotating line buffer with NUM_TAPS column output; BIN_WINDOW_VOTE_EN adds a majority vote
module bin_window_buffer
  import bin_window_pkg::*;
#(
  parameter int NUM_TAPS = 3,
  parameter int LINE_W   = 640,
  parameter int X_W      = 10
) (
  input logic                bit_clk,
  input logic                reset_n,
  bin_window_buffer_if.slave bus
);

  localparam int                NUM_BUF  = NUM_TAPS + 1;
  localparam int                SEL_W    = $clog2(NUM_BUF);
  localparam logic [X_W:0]      LINE_END = (X_W+1)'(LINE_W);
  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(NUM_BUF - 1);
  localparam logic [SEL_W-1:0]  FULL_CNT = SEL_W'(NUM_TAPS);

  logic [23:0]         pixel_d1;
  logic                h_sync_d1;
  logic                v_sync_d1;
  logic [X_W-1:0]      x_d1;
  logic [7:0]          thresh_d1;

  logic                white_d2;
  logic                wren_d2;
  logic                h_sync_d2;
  logic                v_sync_d2;
  logic                in_range_d2;
  logic [X_W-1:0]      x_d2;
  logic [SEL_W-1:0]    wr_sel_rd;

  logic [SEL_W-1:0]    wr_sel;
  logic [SEL_W-1:0]    fill_cnt;
  logic [NUM_BUF-1:0]  rd_q;

  logic [NUM_TAPS-1:0] taps_q;
  logic                tap_valid_q;
  logic [X_W-1:0]      tap_x_q;

  logic                white;
  logic                in_range_d1;
  logic                h_fall;
  logic                v_rise;
  logic [NUM_TAPS-1:0] taps_c;
  logic                tap_valid_c;

  assign white       = luma(pixel_d1) > thresh_d1;
  assign in_range_d1 = {1'b0, x_d1} < LINE_END;
  assign h_fall      = h_sync_d2 & ~h_sync_d1;
  assign v_rise      = v_sync_d1 & ~v_sync_d2;

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_d1  <= '0;
      h_sync_d1 <= 1'b0;
      v_sync_d1 <= 1'b0;
      x_d1      <= '0;
      thresh_d1 <= '0;
    end else begin
      pixel_d1  <= bus.pixel;
      h_sync_d1 <= bus.h_sync;
      v_sync_d1 <= bus.v_sync;
      x_d1      <= bus.x_cont;
      thresh_d1 <= bus.thresh;
    end
  end

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      white_d2    <= 1'b0;
      wren_d2     <= 1'b0;
      h_sync_d2   <= 1'b0;
      v_sync_d2   <= 1'b0;
      in_range_d2 <= 1'b0;
      x_d2        <= '0;
      wr_sel_rd   <= '0;
    end else begin
      white_d2    <= white;
      wren_d2     <= h_sync_d1 & in_range_d1;
      h_sync_d2   <= h_sync_d1;
      v_sync_d2   <= v_sync_d1;
      in_range_d2 <= in_range_d1;
      x_d2        <= x_d1;
      wr_sel_rd   <= wr_sel;
    end
  end

  // A frame start overrides a line advance landing on the same cycle.
  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel   <= '0;
      fill_cnt <= '0;
    end else if (v_rise) begin
      wr_sel   <= '0;
      fill_cnt <= '0;
    end else if (h_fall) begin
      wr_sel <= (wr_sel == LAST_SEL) ? '0 : wr_sel + 1'b1;
      if (fill_cnt != FULL_CNT) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    bin_line_ram #(
      .DEPTH (LINE_W),
      .AW    (X_W)
    ) u_ram (
      .clk       (bit_clk),
      .wren      (wren_d2 && (wr_sel == SEL_W'(b))),
      .wraddress (x_d2),
      .data      (white_d2),
      .rdaddress (x_d1),
      .q         (rd_q[b])
    );
  end

  always_comb begin
    taps_c = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      taps_c[k] = rd_q[SEL_W'(bank_idx(int'(wr_sel_rd), k, NUM_BUF))];
    end
  end

  assign tap_valid_c = h_sync_d2 & in_range_d2 & (fill_cnt == FULL_CNT);

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      taps_q      <= '0;
      tap_valid_q <= 1'b0;
      tap_x_q     <= '0;
    end else begin
      taps_q      <= tap_valid_c ? taps_c : '0;
      tap_valid_q <= tap_valid_c;
      tap_x_q     <= x_d2;
    end
  end

  assign bus.taps      = taps_q;
  assign bus.tap_valid = tap_valid_q;
  assign bus.tap_x     = tap_x_q;

`ifdef BIN_WINDOW_VOTE_EN
  logic [SEL_W-1:0] ones;
  logic             vote_q;
  logic             vote_valid_q;

  always_comb begin
    ones = '0;
    for (int k = 0; k < NUM_TAPS; k++) ones = ones + SEL_W'(taps_q[k]);
  end

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      vote_q       <= 1'b0;
      vote_valid_q <= 1'b0;
    end else begin
      vote_q       <= ones > SEL_W'(NUM_TAPS / 2);
      vote_valid_q <= tap_valid_q;
    end
  end

  assign bus.vote       = vote_q;
  assign bus.vote_valid = vote_valid_q;
`endif

endmodule

// File: tb/tb_bin_window_buffer.sv
// tb/tb_bin_window_buffer.sv - directed self-checking bench for bin_window_buffer
module tb_bin_window_buffer;

  localparam int NUM_TAPS = 3;
  localparam int LINE_W   = 16;
  localparam int X_W      = 5;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GRAY  = {8'd200, 8'd200, 8'd200};

  logic bit_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 bit_clk = ~bit_clk;

  bin_window_buffer_if #(.NUM_TAPS(NUM_TAPS), .X_W(X_W)) bus ();

  bin_window_buffer #(
    .NUM_TAPS (NUM_TAPS),
    .LINE_W   (LINE_W),
    .X_W      (X_W)
  ) dut (
    .bit_clk (bit_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [23:0]         line_pix [LINE_W];
  logic [7:0]          line_th  [LINE_W];
  logic [NUM_TAPS-1:0] cap_taps [2**X_W];
  int                  cap_cyc  [2**X_W];
  int                  in_cyc   [2**X_W];
  int                  valid_cnt;
  bit                  oob_x_seen;
  bit                  oob_valid;
`ifdef BIN_WINDOW_VOTE_EN
  logic                cap_vote [2**X_W];
  logic [X_W-1:0]      prev_x;
`endif

  always @(posedge bit_clk) cyc++;

  always @(negedge bit_clk) begin
    if (bus.tap_valid) begin
      cap_taps[bus.tap_x] = bus.taps;
      cap_cyc[bus.tap_x]  = cyc;
      valid_cnt++;
      if (int'(bus.tap_x) >= LINE_W) oob_valid = 1'b1;
    end
    if (int'(bus.tap_x) == LINE_W) oob_x_seen = 1'b1;
`ifdef BIN_WINDOW_VOTE_EN
    if (bus.vote_valid) cap_vote[prev_x] = bus.vote;
    prev_x = bus.tap_x;
`endif
  end

  task automatic clear_cap();
    valid_cnt  = 0;
    oob_x_seen = 1'b0;
    oob_valid  = 1'b0;
    for (int i = 0; i < 2**X_W; i++) begin
      cap_taps[i] = '0;
      cap_cyc[i]  = -1;
    end
  endtask

  task automatic fill_line(input logic [23:0] pix, input logic [7:0] th);
    for (int i = 0; i < LINE_W; i++) begin
      line_pix[i] = pix;
      line_th[i]  = th;
    end
  endtask

  task automatic drive_pixel(input int x, input logic [23:0] pix, input logic [7:0] th);
    @(posedge bit_clk); #1;
    bus.pixel  = pix;
    bus.h_sync = 1'b1;
    bus.x_cont = X_W'(x);
    bus.thresh = th;
    in_cyc[x]  = cyc + 1;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) begin
      @(posedge bit_clk); #1;
      bus.pixel  = '0;
      bus.h_sync = 1'b0;
      bus.v_sync = vs;
      bus.x_cont = '0;
    end
  endtask

  task automatic drive_line(input bit vs_end);
    clear_cap();
    for (int x = 0; x < LINE_W; x++) drive_pixel(x, line_pix[x], line_th[x]);
    idle(1, vs_end);
    idle(5, 1'b0);
  endtask

  task automatic frame_start();
    idle(1, 1'b1);
    idle(3, 1'b0);
  endtask

  task automatic test_reset();
    bus.pixel = '0; bus.h_sync = 1'b0; bus.v_sync = 1'b0; bus.x_cont = '0; bus.thresh = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge bit_clk);
    #1;
    checks++; if (bus.taps !== 3'b000) begin failures++; $display("FAIL reset_taps got=%b exp=000", bus.taps); end
    checks++; if (bus.tap_valid !== 1'b0) begin failures++; $display("FAIL reset_tap_valid got=%b exp=0", bus.tap_valid); end
    checks++; if (bus.tap_x !== 5'd0) begin failures++; $display("FAIL reset_tap_x got=%0d exp=0", bus.tap_x); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    fill_line(GRAY, 8'd100);
    for (int l = 0; l < 3; l++) begin
      drive_line(1'b0);
      checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL fill_line%0d_valid got=%0d exp=0", l, valid_cnt); end
    end
    drive_line(1'b0);
    checks++; if (valid_cnt !== LINE_W) begin failures++; $display("FAIL fill_line3_valid got=%0d exp=%0d", valid_cnt, LINE_W); end
    checks++; if (cap_taps[5] !== 3'b111) begin failures++; $display("FAIL fill_taps_x5 got=%b exp=111", cap_taps[5]); end
    checks++; if (cap_cyc[5] - in_cyc[5] !== 2) begin failures++; $display("FAIL fill_latency_x5 got=%0d exp=2", cap_cyc[5] - in_cyc[5]); end
  endtask

  task automatic test_alternate();
    frame_start();
    for (int l = 0; l < 5; l++) begin
      fill_line((l % 2 == 0) ? WHITE : BLACK, 8'd100);
      drive_line(1'b0);
      if (l == 2) begin
        checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL alt_line2_valid got=%0d exp=0", valid_cnt); end
      end
      if (l == 3) begin
        checks++; if (cap_taps[0] !== 3'b101) begin failures++; $display("FAIL alt_line3_taps got=%b exp=101", cap_taps[0]); end
      end
      if (l == 4) begin
        checks++; if (cap_taps[0] !== 3'b010) begin failures++; $display("FAIL alt_line4_taps_x0 got=%b exp=010", cap_taps[0]); end
        checks++; if (cap_taps[LINE_W-1] !== 3'b010) begin failures++; $display("FAIL alt_line4_taps_xlast got=%b exp=010", cap_taps[LINE_W-1]); end
      end
    end
  endtask

  task automatic test_vsync();
    frame_start();
    fill_line(GRAY, 8'd100);
    for (int l = 0; l < 6; l++) drive_line(l == 5);
    checks++; if (dut.wr_sel !== 2'd0) begin failures++; $display("FAIL vsync_wr_sel got=%0d exp=0", dut.wr_sel); end
    for (int l = 0; l < 3; l++) begin
      drive_line(1'b0);
      checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL vsync_line%0d_valid got=%0d exp=0", l, valid_cnt); end
    end
    drive_line(1'b0);
    checks++; if (valid_cnt !== LINE_W) begin failures++; $display("FAIL vsync_line3_valid got=%0d exp=%0d", valid_cnt, LINE_W); end
  endtask

  task automatic test_threshold();
    frame_start();
    fill_line(BLACK, 8'd100);
    line_pix[0] = {8'd102, 8'd102, 8'd102};
    line_pix[1] = {8'd103, 8'd103, 8'd103};
    line_pix[2] = {8'd102, 8'd102, 8'd102}; line_th[2] = 8'd99;
    line_pix[3] = {8'd102, 8'd102, 8'd102};
    drive_line(1'b0);
    fill_line(BLACK, 8'd100);
    for (int l = 0; l < 3; l++) drive_line(1'b0);
    checks++; if (cap_taps[0] !== 3'b000) begin failures++; $display("FAIL thr_y100_t100 got=%b exp=000", cap_taps[0]); end
    checks++; if (cap_taps[1] !== 3'b001) begin failures++; $display("FAIL thr_y101_t100 got=%b exp=001", cap_taps[1]); end
    checks++; if (cap_taps[2] !== 3'b001) begin failures++; $display("FAIL thr_y100_t99 got=%b exp=001", cap_taps[2]); end
    checks++; if (cap_taps[3] !== 3'b000) begin failures++; $display("FAIL thr_back_t100 got=%b exp=000", cap_taps[3]); end
  endtask

  task automatic test_out_of_range();
    clear_cap();
    for (int x = 0; x < LINE_W; x++) drive_pixel(x, WHITE, 8'd100);
    drive_pixel(LINE_W, WHITE, 8'd100);
    idle(6, 1'b0);
    checks++; if (oob_x_seen !== 1'b1) begin failures++; $display("FAIL oob_tap_x_seen got=%b exp=1", oob_x_seen); end
    checks++; if (oob_valid !== 1'b0) begin failures++; $display("FAIL oob_tap_valid got=%b exp=0", oob_valid); end
    checks++; if (valid_cnt !== LINE_W) begin failures++; $display("FAIL oob_valid_cnt got=%0d exp=%0d", valid_cnt, LINE_W); end
  endtask

  task automatic test_reset_midline();
    for (int x = 0; x < 8; x++) drive_pixel(x, WHITE, 8'd100);
    checks++; if (bus.tap_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.tap_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.taps !== 3'b000) begin failures++; $display("FAIL midrst_taps got=%b exp=000", bus.taps); end
    checks++; if (bus.tap_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.tap_valid); end
    checks++; if (bus.tap_x !== 5'd0) begin failures++; $display("FAIL midrst_tap_x got=%0d exp=0", bus.tap_x); end
    idle(2, 1'b0);
    reset_n = 1'b1;
    idle(2, 1'b0);
    fill_line(WHITE, 8'd100);
    for (int l = 0; l < 3; l++) begin
      drive_line(1'b0);
      checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL midrst_line%0d_valid got=%0d exp=0", l, valid_cnt); end
    end
    drive_line(1'b0);
    checks++; if (cap_taps[7] !== 3'b111) begin failures++; $display("FAIL midrst_line3_taps got=%b exp=111", cap_taps[7]); end
  endtask

`ifdef BIN_WINDOW_VOTE_EN
  task automatic test_vote();
    frame_start();
    fill_line(BLACK, 8'd100);
    line_pix[0] = WHITE; line_pix[1] = WHITE;
    drive_line(1'b0);
    fill_line(BLACK, 8'd100);
    line_pix[0] = WHITE;
    drive_line(1'b0);
    fill_line(BLACK, 8'd100);
    drive_line(1'b0);
    drive_line(1'b0);
    checks++; if (cap_taps[0] !== 3'b011) begin failures++; $display("FAIL vote_taps_x0 got=%b exp=011", cap_taps[0]); end
    checks++; if (cap_vote[0] !== 1'b1) begin failures++; $display("FAIL vote_011 got=%b exp=1", cap_vote[0]); end
    checks++; if (cap_vote[1] !== 1'b0) begin failures++; $display("FAIL vote_001 got=%b exp=0", cap_vote[1]); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_alternate();
    test_vsync();
    test_threshold();
    test_out_of_range();
    test_reset_midline();
`ifdef BIN_WINDOW_VOTE_EN
    test_vote();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
